// File: rtl/traffic_light_param.sv
// Main/side intersection controller with pedestrian walk phase, all-red clearance,
// one-shot side-green extension and night flash; single clock with internal tick enable.
module traffic_light_param #(
  parameter int TICK_DIV = 5,
  parameter int CNT_W    = 5,
  parameter int T_MG_MIN = 6,
  parameter int T_MG_MAX = 12,
  parameter int T_Y      = 2,
  parameter int T_AR     = 1,
  parameter int T_WALK   = 3,
  parameter int T_SG     = 6,
  parameter int T_SG_EXT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Sensor,
  input  logic             walkButton,
  input  logic             flashMode,
  output logic             mainLightR,
  output logic             mainLightY,
  output logic             mainLightG,
  output logic             sideLightR,
  output logic             sideLightY,
  output logic             sideLightG,
  output logic             walkLight,
  output logic [CNT_W-1:0] walkCount,
  output logic             tick,
  output logic [3:0]       state
);

  localparam int DIV_W = $clog2(TICK_DIV);

  localparam logic [3:0] S_MG    = 4'd0;
  localparam logic [3:0] S_MY    = 4'd1;
  localparam logic [3:0] S_AR1   = 4'd2;
  localparam logic [3:0] S_WALK  = 4'd3;
  localparam logic [3:0] S_SG    = 4'd4;
  localparam logic [3:0] S_SY    = 4'd5;
  localparam logic [3:0] S_AR2   = 4'd6;
  localparam logic [3:0] S_FLASH = 4'd7;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [CNT_W-1:0] PH_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PH_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MG_MIN_M1 = CNT_W'(T_MG_MIN - 1);
  localparam logic [CNT_W-1:0] MG_MAX_M1 = CNT_W'(T_MG_MAX - 1);
  localparam logic [CNT_W-1:0] Y_M1      = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] AR_M1     = CNT_W'(T_AR - 1);
  localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] WALK_LEN  = CNT_W'(T_WALK);
  localparam logic [CNT_W-1:0] SG_M1     = CNT_W'(T_SG - 1);
  localparam logic [CNT_W-1:0] SG_EXT_M1 = CNT_W'((T_SG_EXT > 0) ? (T_SG_EXT - 1) : 0);
  localparam logic             EXT_EN    = (T_SG_EXT > 0) ? 1'b1 : 1'b0;

  // Lamp vector order: {mainR, mainY, mainG, sideR, sideY, sideG, walk}
  localparam logic [6:0] LAMP_MG   = 7'b0011000;
  localparam logic [6:0] LAMP_MY   = 7'b0101000;
  localparam logic [6:0] LAMP_AR   = 7'b1001000;
  localparam logic [6:0] LAMP_WALK = 7'b1001001;
  localparam logic [6:0] LAMP_SG   = 7'b1000010;
  localparam logic [6:0] LAMP_SY   = 7'b1000100;

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             walk_pend_q, walk_pend_d;
  logic             side_pend_q, side_pend_d;
  logic             ext_used_q, ext_used_d;
  logic             flash_ph_q, flash_ph_d;
  logic [6:0]       lamps_q, lamps_d;
  logic [CNT_W-1:0] walk_cnt_q, walk_cnt_d;
  logic             tick_s;
  logic             enter_walk_s;
  logic             enter_sg_s;

  assign tick_s = (div_q == DIV_LAST);

  // State, counters, request latches and registered lamp outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q       <= DIV_ZERO;
      state_q     <= S_MG;
      phase_q     <= PH_ZERO;
      walk_pend_q <= 1'b0;
      side_pend_q <= 1'b0;
      ext_used_q  <= 1'b0;
      flash_ph_q  <= 1'b0;
      lamps_q     <= LAMP_MG;
      walk_cnt_q  <= PH_ZERO;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      walk_pend_q <= walk_pend_d;
      side_pend_q <= side_pend_d;
      ext_used_q  <= ext_used_d;
      flash_ph_q  <= flash_ph_d;
      lamps_q     <= lamps_d;
      walk_cnt_q  <= walk_cnt_d;
    end
  end

  // Tick divider and next-state / phase sequencing
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    ext_used_d = ext_used_q;
    flash_ph_d = flash_ph_q;
    if (tick_s) begin
      div_d = DIV_ZERO;
    end else begin
      div_d = div_q + DIV_ONE;
    end

    if (tick_s) begin
      if (flashMode) begin
        // Flash request overrides every other transition on this tick
        state_d = S_FLASH;
        if (state_q == S_FLASH) begin
          flash_ph_d = ~flash_ph_q;
          phase_d    = phase_q;
        end else begin
          flash_ph_d = 1'b1;
          phase_d    = PH_ZERO;
        end
      end else begin
        phase_d = phase_q + PH_ONE;
        case (state_q)
          S_MG: begin
            if (((phase_q >= MG_MIN_M1) && (walk_pend_q || side_pend_q)) ||
                (phase_q == MG_MAX_M1)) begin
              state_d = S_MY;
            end else begin
              state_d = S_MG;
            end
          end
          S_MY: begin
            if (phase_q == Y_M1) begin
              state_d = S_AR1;
            end else begin
              state_d = S_MY;
            end
          end
          S_AR1: begin
            if (phase_q != AR_M1) begin
              state_d = S_AR1;
            end else if (walk_pend_q) begin
              state_d = S_WALK;
            end else begin
              state_d = S_SG;
            end
          end
          S_WALK: begin
            if (phase_q == WALK_M1) begin
              state_d = S_SG;
            end else begin
              state_d = S_WALK;
            end
          end
          S_SG: begin
            if (ext_used_q) begin
              if (phase_q == SG_EXT_M1) begin
                state_d = S_SY;
              end else begin
                state_d = S_SG;
              end
            end else if (phase_q == SG_M1) begin
              if (Sensor && EXT_EN) begin
                ext_used_d = 1'b1;
                phase_d    = PH_ZERO;
                state_d    = S_SG;
              end else begin
                state_d = S_SY;
              end
            end else begin
              state_d = S_SG;
            end
          end
          S_SY: begin
            if (phase_q == Y_M1) begin
              state_d = S_AR2;
            end else begin
              state_d = S_SY;
            end
          end
          S_AR2: begin
            if (phase_q == AR_M1) begin
              state_d = S_MG;
            end else begin
              state_d = S_AR2;
            end
          end
          S_FLASH: begin
            state_d = S_AR2;
          end
          default: begin
            state_d = S_MG;
          end
        endcase

        if (state_d != state_q) begin
          phase_d    = PH_ZERO;
          flash_ph_d = 1'b0;
        end else begin
          flash_ph_d = flash_ph_q;
        end
        if ((state_d == S_SG) && (state_q != S_SG)) begin
          ext_used_d = 1'b0;
        end else begin
          ext_used_d = ext_used_d;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  assign enter_walk_s = (state_d == S_WALK) && (state_q != S_WALK);
  assign enter_sg_s   = (state_d == S_SG) && (state_q != S_SG);

  // Request latches sample every clock; clearing on phase entry wins over a new request
  always_comb begin
    walk_pend_d = walk_pend_q;
    side_pend_d = side_pend_q;
    if (enter_walk_s) begin
      walk_pend_d = 1'b0;
    end else if (walkButton && (state_q != S_WALK)) begin
      walk_pend_d = 1'b1;
    end else begin
      walk_pend_d = walk_pend_q;
    end
    if (enter_sg_s) begin
      side_pend_d = 1'b0;
    end else if (Sensor) begin
      side_pend_d = 1'b1;
    end else begin
      side_pend_d = side_pend_q;
    end
  end

  // Lamp decode from the next state so the registered lamps track the state register
  always_comb begin
    lamps_d    = LAMP_AR;
    walk_cnt_d = PH_ZERO;
    case (state_d)
      S_MG:    lamps_d = LAMP_MG;
      S_MY:    lamps_d = LAMP_MY;
      S_AR1:   lamps_d = LAMP_AR;
      S_WALK: begin
        lamps_d    = LAMP_WALK;
        walk_cnt_d = WALK_LEN - phase_d;
      end
      S_SG:    lamps_d = LAMP_SG;
      S_SY:    lamps_d = LAMP_SY;
      S_AR2:   lamps_d = LAMP_AR;
      S_FLASH: lamps_d = {1'b0, flash_ph_d, 1'b0, flash_ph_d, 3'b000};
      default: lamps_d = LAMP_AR;
    endcase
  end

  assign mainLightR = lamps_q[6];
  assign mainLightY = lamps_q[5];
  assign mainLightG = lamps_q[4];
  assign sideLightR = lamps_q[3];
  assign sideLightY = lamps_q[2];
  assign sideLightG = lamps_q[1];
  assign walkLight  = lamps_q[0];
  assign walkCount  = walk_cnt_q;
  assign tick       = tick_s;
  assign state      = state_q;

endmodule

// File: tb/tb_traffic_light_param.sv
// Directed bench for traffic_light_param: phase durations, walk, extension, flash and reset.
module tb_traffic_light_param;

  localparam int TICK_DIV = 5;
  localparam int CNT_W    = 5;

  localparam logic [3:0] S_MG    = 4'd0;
  localparam logic [3:0] S_MY    = 4'd1;
  localparam logic [3:0] S_AR1   = 4'd2;
  localparam logic [3:0] S_WALK  = 4'd3;
  localparam logic [3:0] S_SG    = 4'd4;
  localparam logic [3:0] S_SY    = 4'd5;
  localparam logic [3:0] S_AR2   = 4'd6;
  localparam logic [3:0] S_FLASH = 4'd7;

  logic             clk;
  logic             rst;
  logic             Sensor;
  logic             walkButton;
  logic             flashMode;
  logic             mainLightR, mainLightY, mainLightG;
  logic             sideLightR, sideLightY, sideLightG;
  logic             walkLight;
  logic [CNT_W-1:0] walkCount;
  logic             tick;
  logic [3:0]       state;
  logic [6:0]       lamps_s;

  int n_vec = 0;
  int n_err = 0;

  traffic_light_param #(
    .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .T_MG_MIN(6), .T_MG_MAX(12), .T_Y(2),
    .T_AR(1), .T_WALK(3), .T_SG(6), .T_SG_EXT(3)
  ) dut (
    .clk(clk), .rst(rst), .Sensor(Sensor), .walkButton(walkButton), .flashMode(flashMode),
    .mainLightR(mainLightR), .mainLightY(mainLightY), .mainLightG(mainLightG),
    .sideLightR(sideLightR), .sideLightY(sideLightY), .sideLightG(sideLightG),
    .walkLight(walkLight), .walkCount(walkCount), .tick(tick), .state(state)
  );

  assign lamps_s = {mainLightR, mainLightY, mainLightG, sideLightR, sideLightY, sideLightG, walkLight};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mainR, mainY, mainG, sideR, sideY, sideG, walk} expected for a state
  function automatic logic [6:0] exp_lamps(input logic [3:0] st, input logic fph);
    case (st)
      S_MG:    return 7'b0011000;
      S_MY:    return 7'b0101000;
      S_AR1:   return 7'b1001000;
      S_WALK:  return 7'b1001001;
      S_SG:    return 7'b1000010;
      S_SY:    return 7'b1000100;
      S_AR2:   return 7'b1001000;
      S_FLASH: return {1'b0, fph, 1'b0, fph, 3'b000};
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the negedge just after the next tick edge
  task automatic next_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 4 * TICK_DIV) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) check("tick_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Check entry of a state, then count the ticks spent in it
  task automatic run_state(input string tag, input logic [3:0] st, input int n);
    int cnt = 0;
    check({tag, "_state"}, state, st);
    check({tag, "_lamps"}, lamps_s, exp_lamps(st, 1'b0));
    while (state == st && cnt < 40) begin
      next_tick();
      cnt++;
    end
    check({tag, "_ticks"}, cnt, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, S_MG);
    check({tag, "_lamps"}, lamps_s, exp_lamps(S_MG, 1'b0));
    check({tag, "_tick"}, tick, 0);
    check({tag, "_wcnt"}, walkCount, 0);
  endtask

  initial begin
    int c;
    int cnt;
    rst = 1'b0; Sensor = 1'b0; walkButton = 1'b0; flashMode = 1'b0;

    // Reset hold and first tick
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    c = 0;
    while (tick !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("first_tick", c + 1, TICK_DIV);

    // No requests: MAX main green forces cycling
    run_state("mg_max", S_MG, 12);
    run_state("my", S_MY, 2);
    run_state("ar1", S_AR1, 1);
    run_state("sg_base", S_SG, 6);
    run_state("sy", S_SY, 2);
    run_state("ar2", S_AR2, 1);

    // Walk pulse at MG tick 2 forces early exit after 6 ticks
    check("mg_walk_state", state, S_MG);
    cnt = 0;
    next_tick(); cnt++;
    next_tick(); cnt++;
    walkButton = 1'b1;
    @(negedge clk);
    walkButton = 1'b0;
    while (state == S_MG && cnt < 40) begin
      next_tick();
      cnt++;
    end
    check("mg_walk_ticks", cnt, 6);
    run_state("my_w", S_MY, 2);
    run_state("ar1_w", S_AR1, 1);
    check("walk_state", state, S_WALK);
    check("walk_light", walkLight, 1);
    check("walk_cnt3", walkCount, 3);
    next_tick();
    check("walk_cnt2", walkCount, 2);
    next_tick();
    check("walk_cnt1", walkCount, 1);
    next_tick();
    check("walk_to_sg", state, S_SG);
    check("walk_cnt0", walkCount, 0);
    run_state("sg_after_walk", S_SG, 6);
    run_state("sy_w", S_SY, 2);
    run_state("ar2_w", S_AR2, 1);
    run_state("mg_no_pend", S_MG, 12);

    // Side extension: Sensor held through SG gives a single 3-tick extension
    run_state("my_e", S_MY, 2);
    Sensor = 1'b1;
    run_state("ar1_e", S_AR1, 1);
    run_state("sg_ext", S_SG, 9);
    Sensor = 1'b0;
    run_state("sy_e", S_SY, 2);
    run_state("ar2_e", S_AR2, 1);
    run_state("mg_side", S_MG, 6);
    run_state("my_e2", S_MY, 2);
    run_state("ar1_e2", S_AR1, 1);
    check("sg_noext_state", state, S_SG);
    Sensor = 1'b1;
    cnt = 0;
    repeat (3) begin
      next_tick();
      cnt++;
    end
    Sensor = 1'b0;
    while (state == S_SG && cnt < 40) begin
      next_tick();
      cnt++;
    end
    check("sg_noext_ticks", cnt, 6);
    run_state("sy_e2", S_SY, 2);
    run_state("ar2_e2", S_AR2, 1);
    run_state("mg_side2", S_MG, 6);

    // Flash entry mid-MY, walk request latched during flash
    check("my_f_state", state, S_MY);
    flashMode = 1'b1;
    next_tick();
    check("flash_state", state, S_FLASH);
    check("flash_ph1", lamps_s, exp_lamps(S_FLASH, 1'b1));
    walkButton = 1'b1;
    @(negedge clk);
    walkButton = 1'b0;
    next_tick();
    check("flash_ph0", lamps_s, exp_lamps(S_FLASH, 1'b0));
    next_tick();
    check("flash_ph1b", lamps_s, exp_lamps(S_FLASH, 1'b1));
    flashMode = 1'b0;
    next_tick();
    run_state("ar2_flash", S_AR2, 1);
    run_state("mg_flash_walk", S_MG, 6);
    run_state("my_f", S_MY, 2);
    run_state("ar1_f", S_AR1, 1);

    // Walk button held across WALK is ignored
    walkButton = 1'b1;
    run_state("walk_held", S_WALK, 3);
    walkButton = 1'b0;
    run_state("sg_h", S_SG, 6);
    run_state("sy_h", S_SY, 2);
    run_state("ar2_h", S_AR2, 1);
    run_state("mg_after_held", S_MG, 12);
    run_state("my_h", S_MY, 2);
    run_state("ar1_h", S_AR1, 1);

    // Reset mid-SG aborts straight to MG
    check("sg_r_state", state, S_SG);
    next_tick();
    next_tick();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_sg");
    rst = 1'b1;
    c = 0;
    while (tick !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("first_tick2", c + 1, TICK_DIV);
    @(negedge clk);
    check("tick_width", tick, 0);
    c = 0;
    while (tick !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("tick_period", c + 1, TICK_DIV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
